cpu_serial_reg_bank: RTL and testbench

Parametrised serial-access register bank for the 8-bit CPU. It holds DEPTH registers of WIDTH bits each. A serial port writes a register by framing WIDTH bits, and reads a register back by shifting it out. A combinational parallel read port feeds the datapath. It succeeds the single-register serial shifter by adding addressing, bit framing, readback, abort, error reporting and selectable bit order.

---
 rtl/cpu_serial_pkg.sv | 19 +
 rtl/cpu_serial_shifter.sv | 37 +++
 rtl/cpu_serial_reg_bank.sv | 146 ++++++++++++++
 tb/tb_cpu_serial_reg_bank.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_serial_pkg.sv
// Shared types and width helpers for the serial-access CPU register bank.
package cpu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

    // Address width never drops below one bit, even for a single register.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cpu_serial_shifter.sv
// WIDTH-bit shifter with clear, parallel load and a selectable bit order.
module cpu_serial_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] next_o,
    output logic             bit_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] shifted;

    // next_o is the post-shift word, so a writer can commit the final bit on the same edge.
    assign shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], bit_i} : {bit_i, sh_q[WIDTH-1:1]};
    assign next_o  = shifted;
    assign bit_o   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else if (clr_i) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= load_data_i;
        end else if (shift_i) begin
            sh_q <= shifted;
        end
    end

endmodule

// File: rtl/cpu_serial_reg_bank.sv
// Serial-access register bank: framed serial writes, shifted readback and a
// combinational parallel read port for the datapath.
module cpu_serial_reg_bank
    import cpu_serial_pkg::*;
#(
    parameter int    WIDTH     = 8,
    parameter int    DEPTH     = 4,
    parameter bit    MSB_FIRST = 1'b1,
    localparam int   AW        = addr_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             read_i,
    input  logic             abort_i,
    input  logic [AW-1:0]    addr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic             bit_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output state_e           state_o
);

    localparam int CW = cnt_width(WIDTH);

    // Protocol: start_i/read_i are one-cycle requests taken only while busy_o is low;
    // shift_i strobes one bit per high cycle; done_o (and err_o) pulse one cycle after
    // the last bit; abort_i drops the frame with no done_o.

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q, err_q;
    logic [WIDTH-1:0] regs_q [DEPTH];

    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] sh_next;
    logic             sh_clr, sh_load, sh_shift, sh_in, sh_bit;
    logic             addr_ok, last_bit, frame_done, wr_en;

    assign addr_ok  = ({1'b0, addr_q} < (AW+1)'(DEPTH));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign wr_en    = frame_done && (state_q == WR) && addr_ok;

    always_comb begin
        state_d    = state_q;
        sh_clr     = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_in      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WR;
                    sh_clr  = 1'b1;
                end else if (read_i) begin
                    state_d = RD;
                    sh_load = 1'b1;
                end
            end
            WR, RD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (shift_i) begin
                    sh_shift = 1'b1;
                    sh_in    = (state_q == WR) && bit_i;
                    if (last_bit) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range addresses match no entry, so a readback loads zeros.
    always_comb begin
        load_word = '0;
        rd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (AW'(i) == addr_i) load_word = regs_q[i];
            if (AW'(i) == rd_addr_i) rd_data_o = regs_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= frame_done;
            err_q   <= frame_done && !addr_ok;
            if (sh_clr || sh_load) begin
                addr_q <= addr_i;
                cnt_q  <= '0;
            end else if (sh_shift) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (AW'(i) == addr_q)) regs_q[i] <= sh_next;
            end
        end
    end

    cpu_serial_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (sh_clr),
        .load_i      (sh_load),
        .load_data_i (load_word),
        .shift_i     (sh_shift),
        .bit_i       (sh_in),
        .next_o      (sh_next),
        .bit_o       (sh_bit)
    );

    assign bit_o   = (state_q == RD) && sh_bit;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign state_o = state_q;

    a_done_single: assert property (@(posedge clk_i) disable iff (!rst_ni) done_q |=> !done_q);
    a_err_with_done: assert property (@(posedge clk_i) disable iff (!rst_ni) err_q |-> done_q);

endmodule

// File: tb/tb_cpu_serial_reg_bank.sv
// Bench for cpu_serial_reg_bank: MSB-first, LSB-first and DEPTH=3 instances side by side.
module tb_cpu_serial_reg_bank;
    import cpu_serial_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       start [3];
    logic       read  [3];
    logic       abort [3];
    logic       shift [3];
    logic       bit_in [3];
    logic [1:0] addr [3];
    logic [1:0] rd_addr [3];
    logic       bit_out [3];
    logic       busy [3];
    logic       done [3];
    logic       err [3];
    logic [7:0] rd_data [3];
    state_e     st [3];

    cpu_serial_reg_bank #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .read_i(read[0]), .abort_i(abort[0]),
        .addr_i(addr[0]), .shift_i(shift[0]), .bit_i(bit_in[0]), .bit_o(bit_out[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .rd_addr_i(rd_addr[0]),
        .rd_data_o(rd_data[0]), .state_o(st[0]));

    cpu_serial_reg_bank #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .read_i(read[1]), .abort_i(abort[1]),
        .addr_i(addr[1]), .shift_i(shift[1]), .bit_i(bit_in[1]), .bit_o(bit_out[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .rd_addr_i(rd_addr[1]),
        .rd_data_o(rd_data[1]), .state_o(st[1]));

    cpu_serial_reg_bank #(.WIDTH(8), .DEPTH(3), .MSB_FIRST(1'b1)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .read_i(read[2]), .abort_i(abort[2]),
        .addr_i(addr[2]), .shift_i(shift[2]), .bit_i(bit_in[2]), .bit_o(bit_out[2]),
        .busy_o(busy[2]), .done_o(done[2]), .err_o(err[2]), .rd_addr_i(rd_addr[2]),
        .rd_data_o(rd_data[2]), .state_o(st[2]));

    int depth_of [3] = '{4, 4, 3};
    bit msb_of   [3] = '{1'b1, 1'b0, 1'b1};

    // ---------------- scoreboard ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [0:0] exp_q [$];
    logic [7:0] model_q [3][4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_word(input int k, input logic [1:0] a);
        return (int'(a) < depth_of[k]) ? model_q[k][a] : 8'h00;
    endfunction

    function automatic logic serial_bit(input int k, input logic [7:0] w, input int i);
        return msb_of[k] ? w[7-i] : w[i];
    endfunction

    task automatic chk_bank(input int k, input string tag);
        for (int j = 0; j < 4; j++) begin
            rd_addr[k] = 2'(j);
            #1;
            chk($sformatf("%s_k%0d_rd%0d", tag, k, j), rd_data[k], model_word(k, 2'(j)));
        end
    endtask

    task automatic pop_chk(input int k, input string tag);
        logic [0:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bit_out[k], e);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_frame(input int k, input bit rd, input logic [1:0] a, input logic [7:0] d,
                             input int n, input bit ab, output bit got_done, output bit got_err);
        logic [7:0] w;
        @(negedge clk);
        if (rd) read[k] = 1'b1; else start[k] = 1'b1;
        addr[k] = a;
        if (rd) begin
            w = model_word(k, a);
            for (int i = 0; i < n; i++) exp_q.push_back(serial_bit(k, w, i));
        end
        @(negedge clk);
        read[k]  = 1'b0;
        start[k] = 1'b0;
        chk($sformatf("k%0d_busy_hi", k), busy[k], 1);
        for (int i = 0; i < n; i++) begin
            if (rd) pop_chk(k, $sformatf("k%0d_rdbit%0d", k, i));
            shift[k]  = 1'b1;
            bit_in[k] = rd ? 1'($urandom_range(0, 1)) : serial_bit(k, d, i);
            @(negedge clk);
        end
        shift[k] = 1'b0;
        if (ab) begin
            abort[k] = 1'b1;
            @(negedge clk);
            abort[k] = 1'b0;
        end
        got_done = done[k];
        got_err  = err[k];
        chk($sformatf("k%0d_busy_lo", k), busy[k], 0);
        chk($sformatf("k%0d_bit_idle", k), bit_out[k], 0);
        @(negedge clk);
        chk($sformatf("k%0d_done_once", k), done[k], 0);
        chk($sformatf("k%0d_err_once", k), err[k], 0);
    endtask

    typedef struct {
        int         k;
        bit         rd;
        logic [1:0] a;
        logic [7:0] d;
        int         n;
        bit         ab;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        bit         gd, ge;
        logic [7:0] w;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 0; read[k] = 0; abort[k] = 0; shift[k] = 0; bit_in[k] = 0;
            addr[k] = 0; rd_addr[k] = 0;
            for (int j = 0; j < 4; j++) model_q[k][j] = 8'h00;
        end

        vecs[0]  = '{0, 1'b0, 2'd2, 8'hA5, 8, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{0, 1'b1, 2'd2, 8'h00, 8, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1, 1'b0, 2'd0, 8'hA5, 8, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1, 1'b1, 2'd0, 8'h00, 8, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{0, 1'b0, 2'd1, 8'h3C, 8, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{0, 1'b0, 2'd1, 8'hFF, 5, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{0, 1'b1, 2'd1, 8'h00, 8, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{0, 1'b0, 2'd1, 8'h5A, 8, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2, 1'b0, 2'd3, 8'hFF, 8, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{2, 1'b1, 2'd3, 8'h00, 8, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{2, 1'b0, 2'd2, 8'hC3, 8, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1, 1'b0, 2'd3, 8'($urandom_range(0, 255)), 8, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1, 1'b1, 2'd3, 8'h00, 8, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{0, 1'b1, 2'd2, 8'h00, 3, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_k%0d_busy", k), busy[k], 0);
            chk($sformatf("rst_k%0d_done", k), done[k], 0);
            chk($sformatf("rst_k%0d_err", k), err[k], 0);
            chk($sformatf("rst_k%0d_bit", k), bit_out[k], 0);
            chk_bank(k, "rst");
        end
        rst_n = 1'b1;

        // shift_i and abort_i are ignored in IDLE
        @(negedge clk);
        shift[0] = 1'b1; bit_in[0] = 1'b1; abort[0] = 1'b1;
        repeat (2) @(negedge clk);
        shift[0] = 1'b0; bit_in[0] = 1'b0; abort[0] = 1'b0;
        chk("idle_ignore_busy", busy[0], 0);
        chk_bank(0, "idle_ignore");

        for (int v = 0; v < 14; v++) begin
            run_frame(vecs[v].k, vecs[v].rd, vecs[v].a, vecs[v].d, vecs[v].n, vecs[v].ab, gd, ge);
            chk($sformatf("v%0d_done", v), gd, vecs[v].exp_done);
            chk($sformatf("v%0d_err", v), ge, vecs[v].exp_err);
            if (!vecs[v].rd && vecs[v].exp_done && !vecs[v].exp_err)
                model_q[vecs[v].k][vecs[v].a] = vecs[v].d;
            chk_bank(vecs[v].k, $sformatf("v%0d", v));
        end

        // start_i during a readback is ignored
        @(negedge clk);
        read[0] = 1'b1; addr[0] = 2'd2;
        w = model_word(0, 2'd2);
        for (int i = 0; i < 8; i++) exp_q.push_back(serial_bit(0, w, i));
        @(negedge clk);
        read[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                shift[0] = 1'b0; start[0] = 1'b1; addr[0] = 2'd0;
                @(negedge clk);
                start[0] = 1'b0;
                chk("rd_start_state", st[0], RD);
            end
            pop_chk(0, $sformatf("rd_start_bit%0d", i));
            shift[0] = 1'b1; bit_in[0] = 1'b1;
            @(negedge clk);
        end
        shift[0] = 1'b0;
        chk("rd_start_done", done[0], 1);
        chk("rd_start_busy", busy[0], 0);
        chk_bank(0, "rd_start");

        // abort wins over a coincident final shift
        @(negedge clk);
        start[0] = 1'b1; addr[0] = 2'd0;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            shift[0] = 1'b1; bit_in[0] = serial_bit(0, 8'h11, i);
            if (i == 7) abort[0] = 1'b1;
            @(negedge clk);
        end
        shift[0] = 1'b0; abort[0] = 1'b0;
        chk("ab_last_done", done[0], 0);
        chk("ab_last_busy", busy[0], 0);
        @(negedge clk);
        chk("ab_last_done2", done[0], 0);
        chk_bank(0, "ab_last");

        // start_i and read_i together: the write frame wins
        @(negedge clk);
        start[0] = 1'b1; read[0] = 1'b1; addr[0] = 2'd3;
        @(negedge clk);
        start[0] = 1'b0; read[0] = 1'b0;
        chk("both_state", st[0], WR);
        for (int i = 0; i < 8; i++) begin
            shift[0] = 1'b1; bit_in[0] = serial_bit(0, 8'h96, i);
            @(negedge clk);
        end
        shift[0] = 1'b0;
        chk("both_done", done[0], 1);
        model_q[0][3] = 8'h96;
        chk_bank(0, "both");

        // reset in the middle of a write frame
        @(negedge clk);
        start[2] = 1'b1; addr[2] = 2'd0;
        @(negedge clk);
        start[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift[2] = 1'b1; bit_in[2] = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy[2], 0);
        chk("mid_rst_done", done[2], 0);
        chk("mid_rst_err", err[2], 0);
        chk("mid_rst_bit", bit_out[2], 0);
        chk("mid_rst_state", st[2], IDLE);
        shift[2] = 1'b0; bit_in[2] = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++) model_q[k][j] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("mid_rst_busy_after", busy[2], 0);
        chk("mid_rst_done_after", done[2], 0);
        for (int k = 0; k < 3; k++) chk_bank(k, "mid_rst");

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
